readmg_ctrl: RTL and testbench
==============================

// Module: readmg_ctrl
// PURPOSE
//  Read-side counterpart of the merge-phase DRAM writer. At each phase change it takes
//  the four way end addresses recorded by the writer and issues DRAM read-burst requests
//  that stream ways a..d back into the merger input FIFOs.
//  Bursts are round-robin across the ways. Burst size is shrunk by halving near the end
//  of each way, so no burst starts beyond that way's end address.
// PARAMETERS
//  RBLOCKS   8         max blocks per read burst; power of two, >=1
//  BLK_LOG   6         log2 bytes per block (64 B)
//  WAY_BYTES 32'h1000000  byte stride between way start addresses
// PORTS
//  CLK        in   1   clock
//  RST        in   1   reset
//  pchange    in   1   phase-change pulse; loads a new phase
//  p_last     in   1   last phase: only ways b and d carry data
//  rd_base    in   32  byte address of way a start (sampled on pchange)
//  endadr_a   in   32  end byte address of way a (exclusive), sampled on pchange
//  endadr_b   in   32  end byte address of way b
//  endadr_c   in   32  end byte address of way c
//  endadr_d   in   32  end byte address of way d
//  way_rdy    in   4   bit i: FIFO of way i can accept an RBLOCKS burst
//  rd_ack     in   1   DRAM accepted current request
//  rd_req     out  1   read request valid
//  rd_adr     out  32  burst start byte address
//  rd_blocks  out  32  burst length in blocks
//  rd_way     out  2   way index of current request (0=a..3=d)
//  busy       out  1   phase in progress
//  phase_done out  1   one-cycle pulse when all ways are fully requested
// BEHAVIOUR
//  Reset: RST and CLK are decided: synchronous, active-high reset RST; clock CLK.
//   RST wins over everything. State=IDLE; rd_req, busy and phase_done are 0; rd_adr, rd_blocks,
//   rd_way are 0; rr_ptr=0; done[3:0]=4'hF.
//  Load: pchange without RST, in any state, overrides all other activity. On that edge:
//   - cur[i] <= rd_base + i*WAY_BYTES; end[i] <= endadr_i (32-bit wrap).
//   - done[i] <= (rd_base + i*WAY_BYTES >= endadr_i) | (p_last & (i==0 | i==2)).
//   - rr_ptr <= 0; rd_req <= 0; busy <= 1; state <= ARB.
//   - An rd_ack in that same cycle is ignored; the pending request is abandoned.
//  FSM IDLE -> ARB -> REQ -> ARB ... -> IDLE:
//   IDLE: outputs held; waits for pchange.
//   ARB: if done==4'hF, pulse phase_done=1 for one cycle, set busy<=0, go to IDLE.
//     Otherwise scan ways rr_ptr, rr_ptr+1, ... (mod 4) and pick the first with !done[i] & way_rdy[i].
//     If none qualifies, stay in ARB. If way w is picked:
//     - rd_adr <= cur[w]; rd_way <= w; rd_blocks <= blk(w).
//     - rd_req <= 1; state <= REQ. rd_req is visible 1 cycle after ARB.
//   REQ: rd_req, rd_adr, rd_blocks, rd_way are held stable until rd_ack=1. On the rd_ack edge:
//     - rd_req <= 0; cur[w] <= cur[w] + (rd_blocks << BLK_LOG).
//     - done[w] <= (new cur >= end[w]); rr_ptr <= w+1 (mod 4); state <= ARB.
//   way_rdy is checked only in ARB; dropping it during REQ does not cancel the request.
//  Burst size blk(w):
//   - remain = (end[w]-cur[w]) >> BLK_LOG, unsigned, evaluated only when cur<end.
//   - blk = RBLOCKS, halved repeatedly while blk > remain, floor 1.
//   - If remain==0 (partial tail block), blk=1; the reader discards bytes beyond end.
//  Minimum spacing between consecutive requests is 2 cycles (REQ ack -> ARB -> REQ).
//  Comparisons use 32-bit unsigned arithmetic; end<start is treated as an empty way.
// TESTING
//  T1 reset: RST high 3 cycles with way_rdy=4'hF, rd_ack=1 -> all outputs 0; rd_req stays 0 for 10 cycles
//     without pchange.
//  T2 full phase: rd_base=0, WAY_BYTES=0x1000, endadr_x=base_x+0x1000, way_rdy=4'hF, ack 1 cycle after req ->
//     32 bursts of 8 blocks in order a,b,c,d,a,...; rd_adr sequence 0x0,0x1000,0x2000,0x3000,0x200,...;
//     phase_done pulses once after the 32nd ack.
//  T3 tail shrink: endadr_a=0x2C0 (11 blocks), other ways empty -> bursts (0x000,8),(0x200,2),(0x280,1),
//     then phase_done.
//  T4 p_last=1 with all endadr nonzero -> requests only with rd_way=1 and rd_way=3; ways a and c are never
//     requested.
//  T5 backpressure: way_rdy=4'b0100, rd_ack low 5 cycles -> only way c is served; rd_req, rd_adr and
//     rd_blocks are stable all 5 cycles; no other way is issued.
//  T6 pchange in REQ with rd_ack=1 the same cycle -> ack ignored; rd_req=0 the next cycle; the first new
//     request is way a at the new rd_base.

Source files
------------

// File: rtl/readmg_ctrl_if.sv
// Handshake bundle between the merge-phase read controller and its
// phase source, way FIFOs and DRAM read port.
interface readmg_ctrl_if;
  logic        pchange;
  logic        p_last;
  logic [31:0] rd_base;
  logic [31:0] endadr_a;
  logic [31:0] endadr_b;
  logic [31:0] endadr_c;
  logic [31:0] endadr_d;
  logic [3:0]  way_rdy;
  logic        rd_ack;
  logic        rd_req;
  logic [31:0] rd_adr;
  logic [31:0] rd_blocks;
  logic [1:0]  rd_way;
  logic        busy;
  logic        phase_done;

  modport master (
    input  pchange, p_last, rd_base,
    input  endadr_a, endadr_b,
    input  endadr_c, endadr_d,
    input  way_rdy, rd_ack,
    output rd_req, rd_adr, rd_blocks,
    output rd_way, busy, phase_done
  );

  modport slave (
    output pchange, p_last, rd_base,
    output endadr_a, endadr_b,
    output endadr_c, endadr_d,
    output way_rdy, rd_ack,
    input  rd_req, rd_adr, rd_blocks,
    input  rd_way, busy, phase_done
  );
endinterface

// File: rtl/readmg_ctrl.sv
// Merge-phase DRAM read controller: round-robin read bursts over four
// ways, shrinking bursts by halving near each way's end address.
module readmg_ctrl #(
  parameter int unsigned RBLOCKS   = 8,
  parameter int unsigned BLK_LOG   = 6,
  parameter logic [31:0] WAY_BYTES = 32'h1000000
) (
  input  logic          CLK,
  input  logic          RST,
  readmg_ctrl_if.master bus
);
  localparam int BLK_STEPS = $clog2(RBLOCKS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    REQ  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cur_q [4];
  logic [31:0] end_q [4];
  logic [31:0] base_w [4];
  logic [31:0] endin_w [4];
  logic [3:0]  done_q;
  logic [1:0]  rr_q;
  logic        rd_req_q;
  logic [31:0] rd_adr_q;
  logic [31:0] rd_blocks_q;
  logic [1:0]  rd_way_q;
  logic        busy_q;
  logic        pdone_q;

  logic        pick_ok;
  logic [1:0]  pick_w;
  logic [31:0] remain;
  logic [31:0] pick_blk;
  logic [31:0] nxt_cur;
  logic        do_finish;
  logic        do_issue;
  logic        do_ack;

  assign endin_w[0] = bus.endadr_a;
  assign endin_w[1] = bus.endadr_b;
  assign endin_w[2] = bus.endadr_c;
  assign endin_w[3] = bus.endadr_d;

  always_comb begin
    for (int i = 0; i < 4; i++)
      base_w[i] = bus.rd_base + 32'(i) * WAY_BYTES;
  end

  always_comb begin
    pick_ok = 1'b0;
    pick_w  = rr_q;
    for (int k = 0; k < 4; k++) begin
      if (!pick_ok && !done_q[rr_q + 2'(k)]
          && bus.way_rdy[rr_q + 2'(k)]) begin
        pick_ok = 1'b1;
        pick_w  = rr_q + 2'(k);
      end
    end
  end

  // Halve from the full burst until it fits; ends at 1 for a tail block.
  always_comb begin
    remain   = (end_q[pick_w] - cur_q[pick_w]) >> BLK_LOG;
    pick_blk = 32'(RBLOCKS);
    for (int k = 0; k < BLK_STEPS; k++)
      if (pick_blk > remain)
        pick_blk = pick_blk >> 1;
  end

  assign nxt_cur = cur_q[rd_way_q] + (rd_blocks_q << BLK_LOG);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.pchange) state_d = ARB;
    else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        ARB: begin
          if (&done_q)      state_d = IDLE;
          else if (pick_ok) state_d = REQ;
        end
        REQ: if (bus.rd_ack) state_d = ARB;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    do_finish = 1'b0;
    do_issue  = 1'b0;
    do_ack    = 1'b0;
    if (!bus.pchange) begin
      unique case (1'b1)
        (state_q == ARB): begin
          do_finish = &done_q;
          do_issue  = ~&done_q & pick_ok;
        end
        (state_q == REQ): do_ack = bus.rd_ack;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_req_q    <= 1'b0;
      rd_adr_q    <= '0;
      rd_blocks_q <= '0;
      rd_way_q    <= '0;
      busy_q      <= 1'b0;
      pdone_q     <= 1'b0;
      rr_q        <= '0;
      done_q      <= 4'hF;
      for (int i = 0; i < 4; i++) begin
        cur_q[i] <= '0;
        end_q[i] <= '0;
      end
    end else begin
      pdone_q <= do_finish;
      if (bus.pchange) begin
        for (int i = 0; i < 4; i++) begin
          cur_q[i]  <= base_w[i];
          end_q[i]  <= endin_w[i];
          done_q[i] <= (base_w[i] >= endin_w[i])
                     | (bus.p_last & (i % 2 == 0));
        end
        rr_q     <= '0;
        rd_req_q <= 1'b0;
        busy_q   <= 1'b1;
      end else if (do_finish) begin
        busy_q <= 1'b0;
      end else if (do_issue) begin
        rd_adr_q    <= cur_q[pick_w];
        rd_way_q    <= pick_w;
        rd_blocks_q <= pick_blk;
        rd_req_q    <= 1'b1;
      end else if (do_ack) begin
        rd_req_q         <= 1'b0;
        cur_q[rd_way_q]  <= nxt_cur;
        done_q[rd_way_q] <= (nxt_cur >= end_q[rd_way_q]);
        rr_q             <= rd_way_q + 2'd1;
      end
    end
  end

  assign bus.rd_req     = rd_req_q;
  assign bus.rd_adr     = rd_adr_q;
  assign bus.rd_blocks  = rd_blocks_q;
  assign bus.rd_way     = rd_way_q;
  assign bus.busy       = busy_q;
  assign bus.phase_done = pdone_q;
endmodule

// File: tb/tb_readmg_ctrl.sv
// Bench for readmg_ctrl: directed phases plus random phases checked
// against a per-way burst list and round-robin choice model.
module tb_readmg_ctrl;
  localparam int          RB = 8;
  localparam int          BL = 6;
  localparam logic [31:0] WB = 32'h1000;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [1:0]  w;
    logic [31:0] a;
    logic [31:0] b;
  } burst_t;

  burst_t mq[$];

  readmg_ctrl_if bus();

  readmg_ctrl #(
    .RBLOCKS(RB),
    .BLK_LOG(BL),
    .WAY_BYTES(WB)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [31:0] base,
                       input logic [31:0] e0, e1, e2, e3,
                       input logic pl);
    logic [31:0] e[4];
    e = '{e0, e1, e2, e3};
    mq.delete();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] s;
      s = base + 32'(i) * WB;
      if (pl && (i == 0 || i == 2)) continue;
      while (s < e[i]) begin
        logic [31:0] rem;
        int blk;
        rem = (e[i] - s) >> BL;
        if (rem >= RB) blk = RB;
        else if (rem == 0) blk = 1;
        else begin
          blk = 1;
          while (32'(blk * 2) <= rem) blk = blk * 2;
        end
        mq.push_back('{w: 2'(i), a: s, b: 32'(blk)});
        s = s + (32'(blk) << BL);
      end
    end
  endtask

  function automatic bit pending(input int w);
    foreach (mq[j]) if (mq[j].w == 2'(w)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick(input int rr, input logic [3:0] rdy);
    for (int k = 0; k < 4; k++) begin
      int w;
      w = (rr + k) % 4;
      if (rdy[w] && pending(w)) return w;
    end
    return -1;
  endfunction

  task automatic load(input logic [31:0] base,
                      input logic [31:0] e0, e1, e2, e3,
                      input logic pl, input logic [3:0] rdy,
                      input logic ack);
    build(base, e0, e1, e2, e3, pl);
    bus.rd_base  = base;
    bus.endadr_a = e0;
    bus.endadr_b = e1;
    bus.endadr_c = e2;
    bus.endadr_d = e3;
    bus.p_last   = pl;
    bus.way_rdy  = rdy;
    bus.rd_ack   = ack;
    bus.pchange  = 1'b1;
    @(posedge CLK); #1;
    bus.pchange = 1'b0;
    bus.rd_ack  = 1'b0;
    chk("load_busy", 32'(bus.busy), 32'd1);
    chk("load_req", 32'(bus.rd_req), 32'd0);
  endtask

  task automatic drive(input int dmin, input int dmax,
                       output logic [1:0] fw,
                       output logic [31:0] fa,
                       output int nreq);
    int rr = 0, pulses = 0, stall = 0;
    int cyc = 0, d = 0, post = 0;
    logic inreq = 1'b0;
    logic [31:0] ca = 0, cb = 0;
    logic [1:0] cw = 0;
    fw = 0;
    fa = 0;
    nreq = 0;
    while (cyc < 4000 && post < 3) begin
      if (pulses > 0) post++;
      if (bus.phase_done) pulses++;
      if (bus.rd_ack) begin
        bus.rd_ack = 1'b0;
        chk("req_drop", 32'(bus.rd_req), 32'd0);
        inreq = 1'b0;
      end else if (bus.rd_req) begin
        if (!inreq) begin
          int pw;
          pw = pick(rr, bus.way_rdy);
          chk("way", 32'(bus.rd_way), 32'(pw));
          if (pw >= 0) begin
            foreach (mq[j]) begin
              if (mq[j].w == 2'(pw)) begin
                chk("adr", bus.rd_adr, mq[j].a);
                chk("blocks", bus.rd_blocks, mq[j].b);
                mq.delete(j);
                break;
              end
            end
            rr = (pw + 1) % 4;
          end
          if (nreq == 0) begin
            fw = bus.rd_way;
            fa = bus.rd_adr;
          end
          nreq++;
          ca = bus.rd_adr;
          cb = bus.rd_blocks;
          cw = bus.rd_way;
          inreq = 1'b1;
          d = $urandom_range(dmax, dmin);
        end else begin
          chk("hold_adr", bus.rd_adr, ca);
          chk("hold_blk", bus.rd_blocks, cb);
          chk("hold_way", 32'(bus.rd_way), 32'(cw));
        end
        if (d == 0) bus.rd_ack = 1'b1;
        else d--;
        stall = 0;
      end else begin
        stall++;
        if (stall >= 3 && pulses == 0 && bus.way_rdy != 4'hF) begin
          bus.way_rdy = 4'hF;
          stall = 0;
        end
      end
      @(posedge CLK); #1;
      cyc++;
    end
    chk("timeout", 32'(cyc < 4000), 32'd1);
    chk("pulses", 32'(pulses), 32'd1);
    chk("left", 32'(mq.size()), 32'd0);
    chk("end_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [1:0]  fw;
    logic [31:0] fa;
    int          n;
    int          cyc;
    bus.pchange  = 1'b0;
    bus.p_last   = 1'b0;
    bus.rd_base  = '0;
    bus.endadr_a = '0;
    bus.endadr_b = '0;
    bus.endadr_c = '0;
    bus.endadr_d = '0;
    bus.way_rdy  = 4'hF;
    bus.rd_ack   = 1'b1;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req", 32'(bus.rd_req), 32'd0);
    chk("rst_adr", bus.rd_adr, 32'd0);
    chk("rst_blk", bus.rd_blocks, 32'd0);
    chk("rst_way", 32'(bus.rd_way), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pdone", 32'(bus.phase_done), 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      chk("idle_req", 32'(bus.rd_req), 32'd0);
    end
    bus.rd_ack = 1'b0;

    load(32'h0, 32'h1000, 32'h2000, 32'h3000, 32'h4000,
         1'b0, 4'hF, 1'b0);
    drive(0, 0, fw, fa, n);
    chk("t2_count", 32'(n), 32'd32);

    load(32'h0, 32'h2C0, 32'h1000, 32'h2000, 32'h3000,
         1'b0, 4'hF, 1'b0);
    drive(0, 1, fw, fa, n);
    chk("t3_count", 32'(n), 32'd3);

    load(32'h10000, 32'h10400, 32'h11300, 32'h12200, 32'h13500,
         1'b1, 4'hF, 1'b0);
    drive(0, 2, fw, fa, n);
    chk("t4_first_way", 32'(fw), 32'd1);

    load(32'h20000, 32'h20200, 32'h21200, 32'h22400, 32'h23200,
         1'b0, 4'b0100, 1'b0);
    drive(5, 5, fw, fa, n);
    chk("t5_first_way", 32'(fw), 32'd2);

    load(32'h0, 32'h1000, 32'h2000, 32'h3000, 32'h4000,
         1'b0, 4'hF, 1'b0);
    cyc = 0;
    while (!bus.rd_req && cyc < 20) begin
      @(posedge CLK); #1;
      cyc++;
    end
    chk("t6_req_seen", 32'(bus.rd_req), 32'd1);
    load(32'h40000, 32'h40600, 32'h41100, 32'h42300, 32'h43000,
         1'b0, 4'hF, 1'b1);
    drive(0, 1, fw, fa, n);
    chk("t6_first_way", 32'(fw), 32'd0);
    chk("t6_first_adr", fa, 32'h40000);

    for (int p = 0; p < 8; p++) begin
      logic [31:0] base;
      logic [31:0] e[4];
      base = 32'($urandom_range(32'h1000, 32'hF0000));
      for (int i = 0; i < 4; i++) begin
        logic [31:0] st;
        st = base + 32'(i) * WB;
        if ($urandom_range(0, 5) == 0)
          e[i] = st - 32'($urandom_range(1, 32'h100));
        else
          e[i] = st + 32'($urandom_range(0, 32'h700));
      end
      load(base, e[0], e[1], e[2], e[3],
           1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 1'b0);
      drive(0, $urandom_range(0, 3), fw, fa, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
